decode_unit: RTL and testbench

Decode stage that drives the ALU's decode-side interface (enable, operator, operand A/B). Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake and decodes ADD/SUB/SLT/ADDI/SLTI into `alu_opcode_e` operations. Reads operands from an internal 32x32 register file and holds one decoded operation in an output register. A per-register busy scoreboard stalls read-after-write and write-after-write hazards until the result returns on the writeback port.

---
 rtl/decode_unit_pkg.sv | 31 +++
 rtl/decode_unit_if.sv | 30 +++
 rtl/decode_unit_reg_file.sv | 48 ++++
 rtl/decode_unit.sv | 129 ++++++++++++
 tb/tb_decode_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_unit_pkg.sv
// Shared types and encodings for the decode stage: ALU operator enum,
// RV32I opcode/funct fields used by the decoder, immediate helper.
package decode_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLTS = 4'd5,
    ALU_SLTU = 4'd6
  } alu_opcode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Fetch, ALU-issue and writeback signals of the decode stage bundled together.
interface decode_unit_if;
  import decode_unit_pkg::*;

  logic        instr_valid_ip;
  logic [31:0] instr_ip;
  logic        instr_ready_op;
  logic        alu_enable_op;
  alu_opcode_e alu_operator_op;
  logic [31:0] alu_operand_a_op;
  logic [31:0] alu_operand_b_op;
  logic [4:0]  alu_rd_op;
  logic        alu_ready_ip;
  logic        wb_enable_ip;
  logic [4:0]  wb_addr_ip;
  logic [31:0] wb_data_ip;
  logic        illegal_instr_op;

  modport master (
    input  instr_valid_ip, instr_ip, alu_ready_ip, wb_enable_ip, wb_addr_ip, wb_data_ip,
    output instr_ready_op, alu_enable_op, alu_operator_op, alu_operand_a_op,
           alu_operand_b_op, alu_rd_op, illegal_instr_op
  );

  modport slave (
    output instr_valid_ip, instr_ip, alu_ready_ip, wb_enable_ip, wb_addr_ip, wb_data_ip,
    input  instr_ready_op, alu_enable_op, alu_operator_op, alu_operand_a_op,
           alu_operand_b_op, alu_rd_op, illegal_instr_op
  );
endinterface

// File: rtl/decode_unit_reg_file.sv
// Register file: two combinational read ports with write-through bypass,
// one write port, x0 hardwired to zero, synchronous active-low reset.
module reg_file #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [31:0]       rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [31:0]       rdata_b
);

  // x0 has no storage; reads of address 0 are forced to zero below.
  logic [31:0] regs_reg [1:NUM_REGS-1];

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset) begin
          regs_reg[gi] <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          regs_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_reg[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_reg[raddr_b];
    end
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: RV32I ADD/SUB/SLT/ADDI/SLTI decode, busy scoreboard for
// RAW/WAW stalls, and a one-entry output register toward the ALU.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input logic          clk,
  input logic          reset,
  decode_unit_if.master bus
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.instr_ip[6:0];
  assign rd     = bus.instr_ip[11:7];
  assign funct3 = bus.instr_ip[14:12];
  assign rs1    = bus.instr_ip[19:15];
  assign rs2    = bus.instr_ip[24:20];
  assign funct7 = bus.instr_ip[31:25];

  logic        dec_legal;
  logic        dec_is_op;
  alu_opcode_e dec_operator;

  always_comb begin
    dec_legal    = 1'b0;
    dec_operator = ALU_ADD;
    dec_is_op    = (opcode == OPC_OP);
    case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
          dec_legal    = 1'b1;
          dec_operator = ALU_ADD;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
          dec_legal    = 1'b1;
          dec_operator = ALU_SUB;
        end else if (funct3 == F3_SLT && funct7 == F7_BASE) begin
          dec_legal    = 1'b1;
          dec_operator = ALU_SLTS;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          dec_legal    = 1'b1;
          dec_operator = ALU_ADD;
        end else if (funct3 == F3_SLT) begin
          dec_legal    = 1'b1;
          dec_operator = ALU_SLTS;
        end
      end
      default: ;
    endcase
  end

  logic [31:0] rdata_a, rdata_b;

  reg_file #(.NUM_REGS(NUM_REGS)) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_enable_ip),
    .waddr   (bus.wb_addr_ip),
    .wdata   (bus.wb_data_ip),
    .raddr_a (rs1),
    .rdata_a (rdata_a),
    .raddr_b (rs2),
    .rdata_b (rdata_b)
  );

  out_state_e    state_reg;
  alu_opcode_e   operator_reg;
  logic [31:0]   operand_a_reg, operand_b_reg;
  logic [4:0]    rd_reg;
  logic          illegal_reg;
  logic [NUM_REGS-1:0] busy_reg, busy_next, busy_eff, wb_clear_mask, set_mask;

  logic out_valid, hazard, instr_ready, accept, accept_legal;

  assign out_valid = (state_reg == OUT_FULL);

  // A writeback this cycle already releases its register for hazard purposes.
  assign wb_clear_mask = bus.wb_enable_ip ? (NUM_REGS'(1) << bus.wb_addr_ip) : '0;
  assign busy_eff      = busy_reg & ~wb_clear_mask;

  assign hazard = busy_eff[rs1] | (dec_is_op & busy_eff[rs2]) | ((rd != 5'd0) & busy_eff[rd]);

  assign instr_ready  = reset & (!out_valid | bus.alu_ready_ip) & !hazard;
  assign accept       = bus.instr_valid_ip & instr_ready;
  assign accept_legal = accept & dec_legal;

  assign set_mask  = (accept_legal && rd != 5'd0) ? (NUM_REGS'(1) << rd) : '0;
  assign busy_next = busy_eff | set_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= OUT_EMPTY;
      operator_reg  <= ALU_ADD;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      rd_reg        <= '0;
      illegal_reg   <= 1'b0;
      busy_reg      <= '0;
    end else begin
      illegal_reg <= accept & !dec_legal;
      busy_reg    <= busy_next;
      if (accept_legal) begin
        state_reg     <= OUT_FULL;
        operator_reg  <= dec_operator;
        operand_a_reg <= rdata_a;
        operand_b_reg <= dec_is_op ? rdata_b : imm_i(bus.instr_ip);
        rd_reg        <= rd;
      end else if (bus.alu_ready_ip) begin
        state_reg <= OUT_EMPTY;
      end
    end
  end

  assign bus.instr_ready_op   = instr_ready;
  assign bus.alu_enable_op    = out_valid;
  assign bus.alu_operator_op  = operator_reg;
  assign bus.alu_operand_a_op = operand_a_reg;
  assign bus.alu_operand_b_op = operand_b_reg;
  assign bus.alu_rd_op        = rd_reg;
  assign bus.illegal_instr_op = illegal_reg;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: reference model plus expected-issue queue.
module tb_decode_unit;
  import decode_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_unit_if bus ();

  decode_unit #(.NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  bit          m_valid;
  bit          m_illegal;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, output bit legal,
                                     output logic [31:0] op, output bit is_op);
    legal = 1'b0;
    op    = 32'(ALU_ADD);
    is_op = (ins[6:0] == 7'b0110011);
    if (is_op) begin
      if (ins[14:12] == 3'b000 && ins[31:25] == 7'b0000000) begin legal = 1'b1; op = 32'(ALU_ADD); end
      if (ins[14:12] == 3'b000 && ins[31:25] == 7'b0100000) begin legal = 1'b1; op = 32'(ALU_SUB); end
      if (ins[14:12] == 3'b010 && ins[31:25] == 7'b0000000) begin legal = 1'b1; op = 32'(ALU_SLTS); end
    end else if (ins[6:0] == 7'b0010011) begin
      if (ins[14:12] == 3'b000) begin legal = 1'b1; op = 32'(ALU_ADD); end
      if (ins[14:12] == 3'b010) begin legal = 1'b1; op = 32'(ALU_SLTS); end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_enable_ip && bus.wb_addr_ip == r) return bus.wb_data_ip;
    return m_regs[r];
  endfunction

  // Reference model: advances once per cycle on the falling edge, between input changes.
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("ready_in_reset", 32'(bus.instr_ready_op), 32'd0);
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy    = '0;
      m_valid   = 1'b0;
      m_illegal = 1'b0;
      exp_q.delete();
    end else begin
      bit          legal, is_op, exp_ready, acc;
      logic [31:0] op, busy_eff, ins;
      logic [4:0]  rd, rs1, rs2;
      exp_t        e;

      check_eq("enable", 32'(bus.alu_enable_op), 32'(m_valid));
      check_eq("illegal", 32'(bus.illegal_instr_op), 32'(m_illegal));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("queue_nonempty", 32'd0, 32'd1);
        end else begin
          check_eq("operator", 32'(bus.alu_operator_op), exp_q[0].op);
          check_eq("operand_a", bus.alu_operand_a_op, exp_q[0].a);
          check_eq("operand_b", bus.alu_operand_b_op, exp_q[0].b);
          check_eq("rd", 32'(bus.alu_rd_op), exp_q[0].rd);
        end
      end

      ins = bus.instr_ip;
      rd  = ins[11:7];
      rs1 = ins[19:15];
      rs2 = ins[24:20];
      ref_decode(ins, legal, op, is_op);
      busy_eff = m_busy;
      if (bus.wb_enable_ip) busy_eff[bus.wb_addr_ip] = 1'b0;
      exp_ready = (!m_valid || bus.alu_ready_ip) &&
                  !(busy_eff[rs1] || (is_op && busy_eff[rs2]) || (rd != 5'd0 && busy_eff[rd]));
      if (bus.instr_valid_ip) check_eq("instr_ready", 32'(bus.instr_ready_op), 32'(exp_ready));
      acc = bus.instr_valid_ip && exp_ready;

      if (m_valid && bus.alu_ready_ip && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc && legal) begin
        e.op = op;
        e.a  = m_read(rs1);
        e.b  = is_op ? m_read(rs2) : {{20{ins[31]}}, ins[31:20]};
        e.rd = 32'(rd);
        exp_q.push_back(e);
        if (rd != 5'd0) busy_eff[rd] = 1'b1;
        $display("issue instr=0x%08h op=%0d a=0x%08h b=0x%08h rd=%0d", ins, e.op, e.a, e.b, rd);
      end else if (acc) begin
        $display("illegal instr=0x%08h", ins);
      end
      m_valid   = (acc && legal) ? 1'b1 : (bus.alu_ready_ip ? 1'b0 : m_valid);
      m_illegal = acc && !legal;
      m_busy    = busy_eff;
      if (bus.wb_enable_ip && bus.wb_addr_ip != 5'd0) m_regs[bus.wb_addr_ip] = bus.wb_data_ip;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_enable_ip = 1'b1;
    bus.wb_addr_ip   = addr;
    bus.wb_data_ip   = data;
    tick();
    bus.wb_enable_ip = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins);
    bus.instr_valid_ip = 1'b1;
    bus.instr_ip       = ins;
    tick();
    bus.instr_valid_ip = 1'b0;
  endtask

  initial begin
    reset              = 1'b0;
    bus.instr_valid_ip = 1'b0;
    bus.instr_ip       = '0;
    bus.alu_ready_ip   = 1'b1;
    bus.wb_enable_ip   = 1'b0;
    bus.wb_addr_ip     = '0;
    bus.wb_data_ip     = '0;
    tick(2);
    check_eq("rst_enable", 32'(bus.alu_enable_op), 32'd0);
    check_eq("rst_operator", 32'(bus.alu_operator_op), 32'(ALU_ADD));
    check_eq("rst_a", bus.alu_operand_a_op, 32'd0);
    check_eq("rst_b", bus.alu_operand_b_op, 32'd0);
    check_eq("rst_rd", 32'(bus.alu_rd_op), 32'd0);
    check_eq("rst_illegal", 32'(bus.illegal_instr_op), 32'd0);
    reset = 1'b1;

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    send(32'h002081B3);                 // ADD x3,x1,x2
    send(32'hFFF00213);                 // ADDI x4,x0,-1
    // SUB x5,x3,x1 stalls on x3 until its writeback
    bus.instr_valid_ip = 1'b1;
    bus.instr_ip       = 32'h401182B3;
    tick(2);
    check_eq("stall_ready", 32'(bus.instr_ready_op), 32'd0);
    wb(5'd3, 32'd8);
    bus.instr_valid_ip = 1'b0;
    tick();

    // backpressure: SLTI x7,x1,10 sits in the output while ADD x8 waits
    send(32'h00A0A393);
    bus.alu_ready_ip   = 1'b0;
    bus.instr_valid_ip = 1'b1;
    bus.instr_ip       = 32'h00208433;
    tick(3);
    bus.alu_ready_ip = 1'b1;
    tick();
    bus.instr_valid_ip = 1'b0;
    tick();

    send(32'h00000073);                 // ECALL: illegal
    tick(2);

    wb(5'd0, 32'd7);                    // ignored
    wb(5'd4, 32'hFFFF_FFFF);
    send(32'h001224B3);                 // SLT x9,x4,x1
    send(32'h00008333);                 // ADD x6,x1,x0
    tick();

    // reset while FULL and x3 busy
    bus.alu_ready_ip = 1'b0;
    send(32'h002081B3);
    reset = 1'b0;
    tick();
    reset            = 1'b1;
    bus.alu_ready_ip = 1'b1;
    check_eq("post_rst_enable", 32'(bus.alu_enable_op), 32'd0);
    send(32'h002081B3);                 // x3 must not be busy any more
    send(32'h00008333);
    tick();

    // randomized traffic over x0..x7 with random backpressure and writebacks
    for (int c = 0; c < 300; c++) begin
      int          kind;
      logic [4:0]  r;
      kind = $urandom_range(0, 6);
      case (kind)
        0: bus.instr_ip = enc_r(7'b0000000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(0, 7)));
        1: bus.instr_ip = enc_r(7'b0100000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(0, 7)));
        2: bus.instr_ip = enc_r(7'b0000000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b010, 5'($urandom_range(0, 7)));
        3: bus.instr_ip = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(0, 7)));
        4: bus.instr_ip = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'b010, 5'($urandom_range(0, 7)));
        5: bus.instr_ip = enc_r(7'b0000000, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b001, 5'($urandom_range(0, 7)));
        default: bus.instr_ip = $urandom;
      endcase
      bus.instr_valid_ip = ($urandom_range(0, 3) != 0);
      bus.alu_ready_ip   = ($urandom_range(0, 3) != 0);
      r = 5'($urandom_range(0, 7));
      bus.wb_enable_ip = m_busy[r] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      bus.wb_addr_ip   = r;
      bus.wb_data_ip   = $urandom;
      tick();
    end

    bus.instr_valid_ip = 1'b0;
    bus.wb_enable_ip   = 1'b0;
    bus.alu_ready_ip   = 1'b1;
    tick(3);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
